// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder/subtractor.
// Holds the flag bundle, the groups-per-stage helper and the saturation constants.
package cla_pkg;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
    logic c;
  } alu_flags_t;

  localparam int MAX_W = 64;

  function automatic int num_groups_per_stage(input int width, input int group, input int stages);
    return width / (group * stages);
  endfunction

  localparam int NUM_GROUPS_PER_STAGE = num_groups_per_stage(16, 4, 2);

  // Positive clamp is 0x7F..F, negative clamp is 0x80..0, both in the low `width` bits.
  function automatic logic [MAX_W-1:0] sat_value(input logic sign, input int width);
    logic [MAX_W-1:0] msb;
    msb = MAX_W'(1) << (width - 1);
    return sign ? msb : (msb - MAX_W'(1));
  endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead group: bit sums plus group propagate/generate,
// the group carry-out and the carry entering its top bit (needed for overflow).
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             p,
  output logic             g,
  output logic             cout,
  output logic             c_msb_in
);

  logic [GROUP-1:0] pb;
  logic [GROUP-1:0] gb;
  logic [GROUP:0]   c;
  logic             g_acc;

  assign pb = a ^ b;
  assign gb = a & b;

  always_comb begin
    c     = '0;
    g_acc = 1'b0;
    c[0]  = cin;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = gb[i] | (pb[i] & c[i]);
      g_acc  = gb[i] | (pb[i] & g_acc);
    end
  end

  assign s        = pb ^ c[GROUP-1:0];
  assign p        = &pb;
  assign g        = g_acc;
  assign cout     = c[GROUP];
  assign c_msb_in = c[GROUP-1];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined WIDTH-bit carry-lookahead adder/subtractor with valid/ready and Z/N/V/C flags.
// Define SATURATE_EN to clamp overflowing results to the signed min/max in the last stage.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             flag_c
);

  localparam int SW = WIDTH / STAGES;
  localparam int NG = num_groups_per_stage(WIDTH, GROUP, STAGES);
  localparam int PR = (STAGES > 1) ? STAGES - 1 : 1;

  if ((STAGES < 1) || (WIDTH % (GROUP * STAGES) != 0) || (STAGES > WIDTH / GROUP) ||
      (WIDTH > MAX_W)) begin : g_bad_cfg
    $error("cla_addsub_pipe: illegal WIDTH/GROUP/STAGES combination");
  end

`ifdef SATURATE_EN
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                input logic ovf, input logic sign);
    return ovf ? WIDTH'(sat_value(sign, WIDTH)) : raw;
  endfunction
`endif

  logic                         adv;
  logic [STAGES-1:0]            vld_q, vld_d;
  logic [PR-1:0][WIDTH-1:0]     a_q, a_d, bx_q, bx_d, sum_q, sum_d;
  logic [PR-1:0]                cy_q, cy_d;
  logic [STAGES-1:0][WIDTH-1:0] a_in, bx_in, sum_in;
  logic [STAGES-1:0]            cin_in;
  logic [WIDTH-1:0]             result_q, result_d;
  alu_flags_t                   flags_q, flags_d;

  // A stalled output freezes the whole pipe, so bubbles never collapse.
  assign adv      = !vld_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  assign vld_d[0] = in_valid;
  if (STAGES > 1) begin : g_vld_chain
    assign vld_d[STAGES-1:1] = vld_q[STAGES-2:0];
  end else begin : g_single
    assign a_d   = '0;
    assign bx_d  = '0;
    assign sum_d = '0;
    assign cy_d  = '0;
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [NG:0]      gc;
    logic [NG-1:0]    gp, gg, gco, gcm;
    logic [SW-1:0]    ssum;
    logic [WIDTH-1:0] stage_sum;

    if (s == 0) begin : g_in
      assign a_in[0]   = a;
      assign bx_in[0]  = b ^ {WIDTH{sub}};
      assign cin_in[0] = sub;
      assign sum_in[0] = '0;
    end else begin : g_in
      assign a_in[s]   = a_q[s-1];
      assign bx_in[s]  = bx_q[s-1];
      assign cin_in[s] = cy_q[s-1];
      assign sum_in[s] = sum_q[s-1];
    end

    // Group carries inside the slice come from group P/G, not from group ripple.
    assign gc[0] = cin_in[s];
    for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
        .a        (a_in[s][s*SW + j*GROUP +: GROUP]),
        .b        (bx_in[s][s*SW + j*GROUP +: GROUP]),
        .cin      (gc[j]),
        .s        (ssum[j*GROUP +: GROUP]),
        .p        (gp[j]),
        .g        (gg[j]),
        .cout     (gco[j]),
        .c_msb_in (gcm[j])
      );
      assign gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end

    always_comb begin
      stage_sum              = sum_in[s];
      stage_sum[s*SW +: SW]  = ssum;
    end

    if (s == STAGES - 1) begin : g_last
      logic             ovf;
      logic [WIDTH-1:0] res;
      assign ovf = gc[NG] ^ gcm[NG-1];
`ifdef SATURATE_EN
      assign res = saturate(stage_sum, ovf, a_in[s][WIDTH-1]);
`else
      assign res = stage_sum;
`endif
      assign result_d = res;
      assign flags_d  = alu_flags_t'{z: (res == '0), n: res[WIDTH-1], v: ovf, c: gc[NG]};
    end else begin : g_mid
      assign a_d[s]   = a_in[s];
      assign bx_d[s]  = bx_in[s];
      assign cy_d[s]  = gc[NG];
      assign sum_d[s] = stage_sum;
    end
  end

  // Control and visible outputs: cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else if (adv) begin
      vld_q    <= vld_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  // Inter-stage datapath: operands, partial sums and slice carries.
  always_ff @(posedge clk) begin
    if (adv) begin
      a_q   <= a_d;
      bx_q  <= bx_d;
      sum_q <= sum_d;
      cy_q  <= cy_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign result    = result_q;
  assign flag_z    = flags_q.z;
  assign flag_n    = flags_q.n;
  assign flag_v    = flags_q.v;
  assign flag_c    = flags_q.c;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe: directed boundary cases, backpressure,
// asynchronous reset mid-flight, and a randomized scoreboard run.
module tb_cla_addsub_pipe;

  localparam int WIDTH  = 16;
  localparam int GROUP  = 4;
  localparam int STAGES = 2;
  localparam longint MAXS = (64'sd1 <<< (WIDTH - 1)) - 1;
  localparam longint MINS = -(64'sd1 <<< (WIDTH - 1));

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [3:0]       fl;  // {z, n, v, c}
  } exp_t;

  logic             clk, rst, in_valid, in_ready, sub, out_valid, out_ready;
  logic [WIDTH-1:0] a, b, result;
  logic             flag_z, flag_n, flag_v, flag_c;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  logic hold_pend = 1'b0;
  logic [WIDTH+3:0] held;
  logic last_acc = 1'b0;

  cla_addsub_pipe #(.WIDTH(WIDTH), .GROUP(GROUP), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .flag_c(flag_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on the operands.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic s);
    exp_t   e;
    longint sx, sy, ux, uy, tru;
    logic   c, v;
    logic [WIDTH-1:0] r;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = longint'(x);
    uy  = longint'(y);
    tru = s ? (sx - sy) : (sx + sy);
    c   = s ? (ux >= uy) : ((ux + uy) >= (64'sd1 <<< WIDTH));
    v   = (tru > MAXS) || (tru < MINS);
    r   = tru[WIDTH-1:0];
`ifdef SATURATE_EN
    if (v) r = (tru > 0) ? MAXS[WIDTH-1:0] : MINS[WIDTH-1:0];
`endif
    e.res = r;
    e.fl  = {(r == '0), r[WIDTH-1], v, c};
    return e;
  endfunction

  // One clock cycle: drive at negedge, observe handshakes before the next posedge.
  task automatic tick(input logic iv, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                      input logic isub, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; sub = isub; out_ready = ordy;
    #1;
    if (hold_pend) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", 64'({result, flag_z, flag_n, flag_v, flag_c}), 64'(held));
    end
    chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_beat", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk("result", 64'(result), 64'(e.res));
        chk("flags", 64'({flag_z, flag_n, flag_v, flag_c}), 64'(e.fl));
      end
    end
    hold_pend = out_valid && !out_ready;
    held      = {result, flag_z, flag_n, flag_v, flag_c};
    last_acc  = in_valid && in_ready;
    if (last_acc) q.push_back(model(ia, ib, isub));
  endtask

  task automatic single(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic s, input logic [WIDTH-1:0] er, input logic [3:0] ef);
    int lat = 0;
    tick(1'b1, x, y, s, 1'b1);
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      tick(1'b0, '0, '0, 1'b0, 1'b1);
      if (out_valid) begin
        lat = i;
        chk({tag, "_result"}, 64'(result), 64'(er));
        chk({tag, "_flags"}, 64'({flag_z, flag_n, flag_v, flag_c}), 64'(ef));
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'(STAGES));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && (q.size() != 0 || out_valid); i++) tick(1'b0, '0, '0, 1'b0, 1'b1);
    chk(tag, 64'(q.size()), 64'd0);
  endtask

  function automatic logic [WIDTH-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return '1;
      1: return {1'b0, {(WIDTH-1){1'b1}}};
      2: return {1'b1, {(WIDTH-1){1'b0}}};
      3: return '0;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  logic [WIDTH-1:0] bp_a [4] = '{16'd1, 16'd3, 16'd5, 16'd7};
  logic [WIDTH-1:0] bp_b [4] = '{16'd2, 16'd4, 16'd6, 16'd8};
  logic [WIDTH-1:0] bp_r [4] = '{16'h3, 16'h7, 16'hB, 16'hF};

  initial begin
    int k;
    int acc;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({flag_z, flag_n, flag_v, flag_c}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    single("t1_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b1001);
`ifdef SATURATE_EN
    single("t2_ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 4'b0010);
    single("t3_ovf_sub", 16'h8000, 16'h0001, 1'b1, 16'h8000, 4'b0111);
`else
    single("t2_ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0110);
    single("t3_ovf_sub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b0011);
`endif
    single("t3_sub_eq", 16'h0005, 16'h0005, 1'b1, 16'h0000, 4'b1001);
    single("sub_b0", 16'h1234, 16'h0000, 1'b1, 16'h1234, 4'b0001);
    drain("drain_directed");

    // Backpressure: out_ready low for 5 cycles while feeding 4 beats.
    k = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      tick(k < 4, bp_a[k < 4 ? k : 0], bp_b[k < 4 ? k : 0], 1'b0, 1'b0);
      if (cyc >= STAGES) begin
        chk("bp_held", 64'(result), 64'h3);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      end
      if (last_acc) k++;
    end
    for (int i = 0; i < 4; i++) begin
      tick(k < 4, bp_a[k < 4 ? k : 0], bp_b[k < 4 ? k : 0], 1'b0, 1'b1);
      chk("bp_nogap", 64'(out_valid), 64'd1);
      chk("bp_order", 64'(result), 64'(bp_r[i]));
      if (last_acc) k++;
    end
    drain("drain_bp");

    // Asynchronous reset with beats in flight.
    tick(1'b1, 16'h0011, 16'h0022, 1'b0, 1'b0);
    tick(1'b1, 16'h0033, 16'h0044, 1'b0, 1'b0);
    tick(1'b0, '0, '0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    chk("arst_flags", 64'({flag_z, flag_n, flag_v, flag_c}), 64'd0);
    q.delete();
    hold_pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, '0, '0, 1'b0, 1'b1);
      chk("arst_no_stale", 64'(out_valid), 64'd0);
    end

    // Randomized traffic against the scoreboard.
    acc = 0;
    for (int cyc = 0; cyc < 20000 && acc < 3000; cyc++) begin
      tick($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0);
      if (last_acc) acc++;
    end
    chk("rand_beats", 64'(acc), 64'd3000);
    drain("drain_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
